// File: rtl/hex_display.sv
// Memory-mapped 32-bit value register with byte/halfword/word stores, registered
// read-back, and a 4-digit multiplexed hex 7-segment display of the low 16 bits.
module hex_display #(
    parameter int unsigned REFRESH_LOG2 = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  data_addr,
    input  logic [31:0] data_in,
    input  logic        write_enable,
    input  logic [1:0]  window_size,
    output logic [31:0] data_out,
    output logic [3:0]  anodes,
    output logic [6:0]  segments
);

    localparam logic [REFRESH_LOG2-1:0] CNT_ONE = {{(REFRESH_LOG2-1){1'b0}}, 1'b1};

    logic [31:0]             r_value;
    logic [REFRESH_LOG2-1:0] r_refresh_cnt;

    logic [3:0]  w_byte_en;
    logic [31:0] w_wdata;
    logic [1:0]  w_digit;
    logic [3:0]  w_nibble;

    // Source data is replicated across lanes so every enabled byte lane takes its own slice.
    always_comb begin
        w_byte_en = '0;
        w_wdata   = data_in;
        case (window_size)
            2'b00: begin
                w_byte_en[data_addr] = 1'b1;
                w_wdata              = {4{data_in[7:0]}};
            end
            2'b01: begin
                if (!data_addr[0]) begin
                    w_byte_en = data_addr[1] ? 4'b1100 : 4'b0011;
                    w_wdata   = {2{data_in[15:0]}};
                end
            end
            2'b10: begin
                if (data_addr == 2'b00) begin
                    w_byte_en = '1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_value       <= '0;
            r_refresh_cnt <= '0;
            data_out      <= '0;
        end else begin
            data_out      <= r_value;
            r_refresh_cnt <= r_refresh_cnt + CNT_ONE;
            for (int unsigned i = 0; i < 4; i++) begin
                if (write_enable && w_byte_en[i]) begin
                    r_value[8*i +: 8] <= w_wdata[8*i +: 8];
                end
            end
        end
    end

    assign w_digit = r_refresh_cnt[REFRESH_LOG2-1 -: 2];

    always_comb begin
        anodes = 4'b0001 << w_digit;
        case (w_digit)
            2'd0:    w_nibble = r_value[3:0];
            2'd1:    w_nibble = r_value[7:4];
            2'd2:    w_nibble = r_value[11:8];
            default: w_nibble = r_value[15:12];
        endcase
    end

    // Segment order {a,b,c,d,e,f,g}, active-high.
    always_comb begin
        segments = 7'b0000000;
        case (w_nibble)
            4'h0: segments = 7'b1111110;
            4'h1: segments = 7'b0110000;
            4'h2: segments = 7'b1101101;
            4'h3: segments = 7'b1111001;
            4'h4: segments = 7'b0110011;
            4'h5: segments = 7'b1011011;
            4'h6: segments = 7'b1011111;
            4'h7: segments = 7'b1110000;
            4'h8: segments = 7'b1111111;
            4'h9: segments = 7'b1111011;
            4'hA: segments = 7'b1110111;
            4'hB: segments = 7'b0011111;
            4'hC: segments = 7'b1001110;
            4'hD: segments = 7'b0111101;
            4'hE: segments = 7'b1001111;
            default: segments = 7'b1000111;
        endcase
    end

endmodule

// File: tb/tb_hex_display.sv
// Self-checking bench for hex_display: byte-lane arithmetic model checked every
// cycle, plus directed literal expectations for the main scenarios.
module tb_hex_display;

    logic        clk;
    logic        rst;
    logic [1:0]  data_addr;
    logic [31:0] data_in;
    logic        write_enable;
    logic [1:0]  window_size;
    logic [31:0] data_out;
    logic [3:0]  anodes;
    logic [6:0]  segments;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 0;

    logic [31:0] m_value;
    logic [31:0] m_dout;
    int          m_cnt;
    logic [6:0]  font [16];

    hex_display #(.REFRESH_LOG2(4)) dut (
        .clk(clk), .rst(rst), .data_addr(data_addr), .data_in(data_in),
        .write_enable(write_enable), .window_size(window_size),
        .data_out(data_out), .anodes(anodes), .segments(segments)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: value as a 32-bit word modified through masks, display index = cycle/4.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_value = 32'h0;
            m_dout  = 32'h0;
            m_cnt   = 0;
        end else begin
            logic [31:0] mask;
            logic [31:0] src;
            int          sh;
            m_dout = m_value;
            m_cnt  = (m_cnt + 1) % 16;
            mask = 32'h0;
            src  = 32'h0;
            sh   = 0;
            if (write_enable) begin
                if (window_size == 2'b00) begin
                    sh = 8 * int'(data_addr);
                    mask = 32'hFF;
                    src = {24'h0, data_in[7:0]};
                end else if (window_size == 2'b01 && data_addr[0] == 1'b0) begin
                    sh = (data_addr == 2'b10) ? 16 : 0;
                    mask = 32'hFFFF;
                    src = {16'h0, data_in[15:0]};
                end else if (window_size == 2'b10 && data_addr == 2'b00) begin
                    mask = 32'hFFFF_FFFF;
                    src = data_in;
                end
                m_value = (m_value & ~(mask << sh)) | (src << sh);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            int d;
            logic [3:0] nib;
            d   = m_cnt / 4;
            nib = 4'((m_value >> (4 * d)) & 32'hF);
            check("model_data_out", data_out, m_dout);
            check("model_anodes", {28'h0, anodes}, 32'h1 << d);
            check("model_segments", {25'h0, segments}, {25'h0, font[nib]});
        end
    end

    task automatic wr(input logic [1:0] size, input logic [1:0] addr, input logic [31:0] d);
        write_enable = 1'b1;
        window_size  = size;
        data_addr    = addr;
        data_in      = d;
        @(negedge clk);
    endtask

    task automatic idle();
        write_enable = 1'b0;
        window_size  = 2'b11;
        data_addr    = 2'b00;
        data_in      = 32'h0;
        @(negedge clk);
    endtask

    initial begin
        font[0]  = 7'b1111110; font[1]  = 7'b0110000; font[2]  = 7'b1101101; font[3]  = 7'b1111001;
        font[4]  = 7'b0110011; font[5]  = 7'b1011011; font[6]  = 7'b1011111; font[7]  = 7'b1110000;
        font[8]  = 7'b1111111; font[9]  = 7'b1111011; font[10] = 7'b1110111; font[11] = 7'b0011111;
        font[12] = 7'b1001110; font[13] = 7'b0111101; font[14] = 7'b1001111; font[15] = 7'b1000111;

        rst = 1'b0; write_enable = 1'b0; window_size = 2'b11; data_addr = 2'b00; data_in = 32'h0;

        // 1: reset between edges takes effect immediately
        #7 rst = 1'b1;
        #1;
        check("rst_data_out", data_out, 32'h0);
        check("rst_anodes", {28'h0, anodes}, 32'h1);
        check("rst_segments", {25'h0, segments}, {25'h0, 7'b1111110});
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        repeat (3) @(negedge clk);
        check("hold_digit0", {28'h0, anodes}, 32'h1);
        @(negedge clk);
        check("step_digit1", {28'h0, anodes}, 32'h2);

        // 2: word write and digit walk
        wr(2'b10, 2'b00, 32'hDEAD_BEEF);
        check("word_pre_store", data_out, 32'h0);
        idle();
        check("word_write", data_out, 32'hDEAD_BEEF);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            case (anodes)
                4'b0001: check("walk_d0_F", {25'h0, segments}, {25'h0, 7'b1000111});
                4'b0010: check("walk_d1_E", {25'h0, segments}, {25'h0, 7'b1001111});
                4'b0100: check("walk_d2_E", {25'h0, segments}, {25'h0, 7'b1001111});
                4'b1000: check("walk_d3_b", {25'h0, segments}, {25'h0, 7'b0011111});
                default: check("walk_onehot", {28'h0, anodes}, 32'h1);
            endcase
        end

        // 3: byte and halfword writes
        wr(2'b00, 2'b10, 32'h0000_005A);
        idle();
        check("byte_addr2", data_out, 32'hDE5A_BEEF);
        wr(2'b01, 2'b10, 32'h0000_1234);
        idle();
        check("half_addr2", data_out, 32'h1234_BEEF);

        // 4: misaligned and no-access stores leave the value alone
        wr(2'b10, 2'b01, 32'h0);
        wr(2'b01, 2'b11, 32'h0);
        wr(2'b01, 2'b01, 32'h0);
        wr(2'b11, 2'b00, 32'h0);
        idle();
        check("ignored_writes", data_out, 32'h1234_BEEF);
        wr(2'b00, 2'b11, 32'hFFFF_FF77);
        idle();
        check("byte_addr3", data_out, 32'h7734_BEEF);
        wr(2'b01, 2'b00, 32'hFFFF_CAFE);
        idle();
        check("half_addr0", data_out, 32'h7734_CAFE);

        // 5: read concurrent with a store returns pre-store value
        wr(2'b10, 2'b00, 32'h0000_0123);
        wr(2'b10, 2'b00, 32'hFFFF_FFFF);
        check("read_during_write", data_out, 32'h0000_0123);
        idle();
        check("read_after_write", data_out, 32'hFFFF_FFFF);

        // 6: reset during a word write discards it
        idle();
        write_enable = 1'b1; window_size = 2'b10; data_addr = 2'b00; data_in = 32'hAAAA_5555;
        #2 rst = 1'b1;
        #1;
        check("midrst_data_out", data_out, 32'h0);
        check("midrst_anodes", {28'h0, anodes}, 32'h1);
        check("midrst_segments", {25'h0, segments}, {25'h0, 7'b1111110});
        @(negedge clk);
        write_enable = 1'b0; window_size = 2'b11; data_in = 32'h0;
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("midrst_write_lost", data_out, 32'h0);
        check("midrst_cnt_restart", {28'h0, anodes}, 32'h1);

        repeat (8) @(negedge clk);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
